// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - datapath-side bundle: instruction/stop inputs and control strobes
interface control_sequencer_if;
  logic [31:0] ir;
  logic        stop;
  logic        PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, read, write;
  logic        IRin, Yin, IncPc, Cout, BAout, Rin, Rout, GRA, GRB, GRC;
  logic [1:0]  mdr_read;
  logic [3:0]  control;
  logic        run;
  logic [4:0]  state;

  modport master (
    input  ir, stop,
    output PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, read, write,
    output IRin, Yin, IncPc, Cout, BAout, Rin, Rout, GRA, GRB, GRC,
    output mdr_read, control, run, state
  );

  modport slave (
    output ir, stop,
    input  PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, read, write,
    input  IRin, Yin, IncPc, Cout, BAout, Rin, Rout, GRA, GRB, GRC,
    input  mdr_read, control, run, state
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore instruction sequencer driving datapath control strobes
module control_sequencer (
  input  logic                       clk,
  input  logic                       reset,
  control_sequencer_if.master        bus
);
  localparam logic [4:0] S_RST  = 5'd0;
  localparam logic [4:0] S_T0   = 5'd1;
  localparam logic [4:0] S_T1   = 5'd2;
  localparam logic [4:0] S_T2   = 5'd3;
  localparam logic [4:0] S_T3   = 5'd4;
  localparam logic [4:0] S_T4   = 5'd5;
  localparam logic [4:0] S_T5   = 5'd6;
  localparam logic [4:0] S_T6   = 5'd7;
  localparam logic [4:0] S_T7   = 5'd8;
  localparam logic [4:0] S_HALT = 5'd9;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [4:0] state, state_nxt;
  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_addi, is_halt, is_mem, is_alu;
  logic [4:0] end_nxt;
  logic       unused_ir;

  assign unused_ir = ^bus.ir[26:0];

  assign is_ld   = (opcode == OP_LD);
  assign is_ldi  = (opcode == OP_LDI);
  assign is_st   = (opcode == OP_ST);
  assign is_addi = (opcode == OP_ADDI);
  assign is_halt = (opcode == OP_HALT);
  assign is_mem  = is_ld | is_ldi | is_st;
  assign is_alu  = is_mem | is_addi;
  assign end_nxt = bus.stop ? S_HALT : S_T0;

  // Opcode is captured on the edge into T3 so the T3 strobes decode from a register, not from ir.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_RST;
      opcode <= 5'b00000;
    end else begin
      state <= state_nxt;
      if (state == S_T2) opcode <= bus.ir[31:27];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:  state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (is_halt)     state_nxt = S_HALT;
        else if (is_alu) state_nxt = S_T4;
        else             state_nxt = end_nxt;
      end
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = (is_ldi | is_addi) ? end_nxt : S_T6;
      S_T6:   state_nxt = S_T7;
      S_T7:   state_nxt = end_nxt;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.Zlowin   = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.IncPc    = 1'b0;
    bus.Cout     = 1'b0;
    bus.BAout    = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.GRA      = 1'b0;
    bus.GRB      = 1'b0;
    bus.GRC      = 1'b0;
    bus.mdr_read = 2'b00;
    bus.control  = 4'd0;
    case (state)
      S_T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPc  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout  = 1'b1;
        bus.PCin     = 1'b1;
        bus.read     = 1'b1;
        bus.MDRin    = 1'b1;
        bus.mdr_read = 2'b01;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        bus.GRB   = is_alu;
        bus.Yin   = is_alu;
        bus.BAout = is_mem;
        bus.Rout  = is_addi;
      end
      S_T4: begin
        bus.Cout    = 1'b1;
        bus.Zlowin  = 1'b1;
        bus.control = 4'd2;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_ldi | is_addi) begin
          bus.GRA = 1'b1;
          bus.Rin = 1'b1;
        end else begin
          bus.MARin = 1'b1;
        end
      end
      S_T6: begin
        bus.MDRin = 1'b1;
        if (is_st) begin
          bus.GRA  = 1'b1;
          bus.Rout = 1'b1;
        end else begin
          bus.read     = 1'b1;
          bus.mdr_read = 2'b01;
        end
      end
      S_T7: begin
        if (is_st) begin
          bus.write = 1'b1;
        end else begin
          bus.MDRout = 1'b1;
          bus.GRA    = 1'b1;
          bus.Rin    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.run   = (state != S_HALT);
  assign bus.state = state;
endmodule
